// File: rtl/pipe_memory_access_if.sv
// Data-memory bus between the pipeline memory-access stage (master) and the memory (slave).
interface pipe_memory_access_if;
   logic [31:0] memoryAddress;
   logic [3:0]  memoryByteSelect;
   logic        memoryReadEnable;
   logic        memoryWriteEnable;
   logic [31:0] memoryDataWrite;
   logic [31:0] memoryDataRead;
   logic        memoryBusy;

   modport master (
      output memoryAddress, memoryByteSelect, memoryReadEnable, memoryWriteEnable, memoryDataWrite,
      input  memoryDataRead, memoryBusy
   );

   modport slave (
      input  memoryAddress, memoryByteSelect, memoryReadEnable, memoryWriteEnable, memoryDataWrite,
      output memoryDataRead, memoryBusy
   );
endinterface

// File: rtl/pipe_memory_access.sv
// Pipeline memory-access stage: decodes loads/stores, drives one bus access per instruction,
// stalls the pipe until the bus answers (or times out) and holds the result until the pipe steps.
module pipe_memory_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stepPipe,
   input  logic                 pipeStall,
   input  logic [31:0]          currentInstruction,
   input  logic [31:0]          aluResultData,
   input  logic [31:0]          rs2Data,
   pipe_memory_access_if.master mem,
   output logic [31:0]          loadData,
   output logic                 accessStall,
   output logic                 addressMisaligned,
   output logic                 busTimeout
);
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_ACCESS     = 2'd1;
   localparam logic [1:0] ST_HOLD       = 2'd2;
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [1:0]  state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] load_data_q, load_data_d;
   logic        bus_timeout_q, bus_timeout_d;

   logic        is_load, is_store, size_valid, access_req, in_access;
   logic [1:0]  size, byte_off;
   logic [3:0]  base_mask;
   logic [6:0]  lane_mask;
   logic [31:0] store_data;
   logic        unused_instr_bits;

   assign is_load    = (currentInstruction[6:0] == OPC_LOAD);
   assign is_store   = (currentInstruction[6:0] == OPC_STORE);
   assign size       = currentInstruction[13:12];
   assign size_valid = (size != 2'b11);
   assign byte_off   = aluResultData[1:0];

   // funct3[2] (signedness) and the register fields do not affect the bus access.
   assign unused_instr_bits = ^{currentInstruction[31:14], currentInstruction[11:7]};

   always_comb begin
      base_mask = 4'b0000;
      case (size)
         2'b00:   base_mask = 4'b0001;
         2'b01:   base_mask = 4'b0011;
         2'b10:   base_mask = 4'b1111;
         default: base_mask = 4'b0000;
      endcase
   end

   // Any lane pushed past bit 3 means the access straddles a word boundary.
   assign lane_mask         = {3'b000, base_mask} << byte_off;
   assign addressMisaligned = (is_load || is_store) && !pipeStall && (|lane_mask[6:4]);
   assign access_req        = (is_load || is_store) && !pipeStall && size_valid && !addressMisaligned;
   assign in_access         = (state_q == ST_ACCESS);

   always_comb begin
      store_data = rs2Data;
      case (size)
         2'b00:   store_data = {24'h000000, rs2Data[7:0]} << {byte_off, 3'b000};
         2'b01:   store_data = {16'h0000, rs2Data[15:0]} << {byte_off, 3'b000};
         default: store_data = rs2Data;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      load_data_d   = load_data_q;
      bus_timeout_d = bus_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (access_req) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!mem.memoryBusy) begin
               if (is_load) load_data_d = mem.memoryDataRead;
               state_d = ST_HOLD;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_d == TIMEOUT_LIMIT) begin
                  bus_timeout_d = 1'b1;
                  state_d       = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (stepPipe) begin
               state_d       = ST_IDLE;
               wait_cnt_d    = 8'd0;
               bus_timeout_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= 8'd0;
         load_data_q   <= 32'd0;
         bus_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         load_data_q   <= load_data_d;
         bus_timeout_q <= bus_timeout_d;
      end
   end

   // Stall is gated by reset so the pipe is released the moment reset is applied.
   assign accessStall           = rst && (((state_q == ST_IDLE) && access_req) || in_access);
   assign loadData              = load_data_q;
   assign busTimeout            = bus_timeout_q;
   assign mem.memoryReadEnable  = in_access && is_load;
   assign mem.memoryWriteEnable = in_access && is_store;
   assign mem.memoryAddress     = in_access ? {aluResultData[31:2], 2'b00} : 32'd0;
   assign mem.memoryByteSelect  = in_access ? lane_mask[3:0] : 4'b0000;
   assign mem.memoryDataWrite   = (in_access && is_store) ? store_data : 32'd0;
endmodule

// File: tb/tb_pipe_memory_access.sv
// Self-checking bench for pipe_memory_access: hand-written vector table, corner-case sequences
// and randomized transactions checked against a behavioural model of the access rules.
module tb_pipe_memory_access;
   localparam int TIMEOUT = 4;

   typedef struct {
      logic [1:0]  kind;   // 0 load, 1 store, 2 non-memory
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic        stall;
      int          busy;   // number of ACCESS cycles the bus reports busy
      logic [31:0] rdata;
      logic [22:0] noise;
   } txn_t;

   typedef struct {
      logic        misaligned;
      int          stallCycles;
      logic        re;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  bs;
      logic [31:0] dw;
      logic [31:0] loadData;
      logic        timeout;
      logic        quiet;
      logic        timeoutAfter;
   } obs_t;

   typedef struct {
      txn_t in;
      obs_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stepPipe = 1'b0;
   logic        pipeStall = 1'b0;
   logic [31:0] currentInstruction = 32'h00000013;
   logic [31:0] aluResultData = 32'd0;
   logic [31:0] rs2Data = 32'd0;
   logic [31:0] loadData;
   logic        accessStall, addressMisaligned, busTimeout;

   int          tests = 0;
   int          failures = 0;
   logic [31:0] modelLoad = 32'd0;

   pipe_memory_access_if bus();

   pipe_memory_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .stepPipe(stepPipe), .pipeStall(pipeStall),
      .currentInstruction(currentInstruction), .aluResultData(aluResultData), .rs2Data(rs2Data),
      .mem(bus), .loadData(loadData), .accessStall(accessStall),
      .addressMisaligned(addressMisaligned), .busTimeout(busTimeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkInstr(logic [1:0] kind, logic [1:0] size, logic [22:0] noise);
      logic [6:0] op;
      op = (kind == 2'd0) ? 7'b0000011 : (kind == 2'd1) ? 7'b0100011 : 7'b0110011;
      return {noise[22:6], noise[5], size, noise[4:0], op};
   endfunction

   function automatic txn_t mkTxn(logic [1:0] kind, logic [1:0] size, logic [31:0] addr,
                                  logic [31:0] rs2, logic stall, int busy, logic [31:0] rdata);
      txn_t t;
      t.kind = kind; t.size = size; t.addr = addr; t.rs2 = rs2;
      t.stall = stall; t.busy = busy; t.rdata = rdata; t.noise = '0;
      return t;
   endfunction

   function automatic obs_t mkObs(logic mis, int st, logic re, logic we, logic [31:0] addr,
                                  logic [3:0] bs, logic [31:0] dw, logic [31:0] ld, logic to);
      obs_t o;
      o.misaligned = mis; o.stallCycles = st; o.re = re; o.we = we; o.addr = addr;
      o.bs = bs; o.dw = dw; o.loadData = ld; o.timeout = to; o.quiet = 1'b1; o.timeoutAfter = 1'b0;
      return o;
   endfunction

   // Expected outcome of one instruction, derived from byte counts and offsets.
   function automatic obs_t model(txn_t t, logic [31:0] prevLoad);
      obs_t e;
      int bytes, off;
      bit isMem, req;
      logic [63:0] v;
      e = mkObs(1'b0, 0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, prevLoad, 1'b0);
      isMem = (t.kind < 2'd2) && !t.stall && (t.size != 2'd3);
      bytes = 1 << t.size;
      off = int'(t.addr % 4);
      e.misaligned = isMem && (off + bytes > 4);
      req = isMem && !e.misaligned;
      if (req) begin
         e.re = (t.kind == 2'd0);
         e.we = (t.kind == 2'd1);
         e.addr = t.addr - 32'(off);
         e.bs = 4'(((1 << bytes) - 1) << off);
         if (e.we) begin
            v = {32'd0, t.rs2} % (64'd1 << (8 * bytes));
            e.dw = 32'(v << (8 * off));
         end
         if (t.busy >= TIMEOUT) begin
            e.timeout = 1'b1;
            e.stallCycles = 1 + TIMEOUT;
         end else begin
            e.stallCycles = t.busy + 2;
            if (e.re) e.loadData = t.rdata;
         end
      end
      return e;
   endfunction

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Runs one instruction from IDLE through HOLD and a pipe step, recording what the bus saw.
   task automatic applyStimulus(input txn_t t, output obs_t o);
      int accCycles;
      o = mkObs(1'b0, 0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
      accCycles = 0;
      pipeStall = t.stall;
      currentInstruction = mkInstr(t.kind, t.size, t.noise);
      aluResultData = t.addr;
      rs2Data = t.rs2;
      bus.memoryDataRead = t.rdata;
      stepPipe = 1'b0;
      for (int c = 0; c < 40; c++) begin
         bus.memoryBusy = (accCycles < t.busy);
         #1;
         if (c == 0) o.misaligned = addressMisaligned;
         if (!accessStall) break;
         o.stallCycles++;
         if (bus.memoryReadEnable || bus.memoryWriteEnable) begin
            accCycles++;
            o.re = o.re | bus.memoryReadEnable;
            o.we = o.we | bus.memoryWriteEnable;
            o.addr = bus.memoryAddress;
            o.bs = bus.memoryByteSelect;
            o.dw = bus.memoryDataWrite;
         end
         @(posedge clk); #1;
      end
      o.quiet = !bus.memoryReadEnable && !bus.memoryWriteEnable && !accessStall &&
                (bus.memoryAddress == 32'd0) && (bus.memoryByteSelect == 4'd0) &&
                (bus.memoryDataWrite == 32'd0);
      o.loadData = loadData;
      o.timeout = busTimeout;
      stepPipe = 1'b1;
      currentInstruction = 32'h00000013;
      bus.memoryBusy = 1'b0;
      @(posedge clk); #1;
      stepPipe = 1'b0;
      o.timeoutAfter = busTimeout;
   endtask

   task automatic compareObs(string tag, obs_t got, obs_t exp);
      checkOutput({tag, ".misaligned"}, 32'(got.misaligned), 32'(exp.misaligned));
      checkOutput({tag, ".stallCycles"}, got.stallCycles, exp.stallCycles);
      checkOutput({tag, ".readEn"}, 32'(got.re), 32'(exp.re));
      checkOutput({tag, ".writeEn"}, 32'(got.we), 32'(exp.we));
      checkOutput({tag, ".address"}, got.addr, exp.addr);
      checkOutput({tag, ".byteSelect"}, 32'(got.bs), 32'(exp.bs));
      checkOutput({tag, ".dataWrite"}, got.dw, exp.dw);
      checkOutput({tag, ".loadData"}, got.loadData, exp.loadData);
      checkOutput({tag, ".busTimeout"}, 32'(got.timeout), 32'(exp.timeout));
      checkOutput({tag, ".holdQuiet"}, 32'(got.quiet), 32'(exp.quiet));
      checkOutput({tag, ".timeoutCleared"}, 32'(got.timeoutAfter), 32'(exp.timeoutAfter));
   endtask

   initial begin
      vec_t vecs[12];
      obs_t got, exp;
      txn_t t;

      vecs[0]  = '{mkTxn(0, 2, 32'h100, 0, 0, 0, 32'hDEADBEEF),
                   mkObs(0, 2, 1, 0, 32'h100, 4'hF, 0, 32'hDEADBEEF, 0)};
      vecs[1]  = '{mkTxn(1, 0, 32'h203, 32'h000000A5, 0, 0, 0),
                   mkObs(0, 2, 0, 1, 32'h200, 4'h8, 32'hA5000000, 32'hDEADBEEF, 0)};
      vecs[2]  = '{mkTxn(0, 1, 32'h3, 0, 0, 0, 32'h12345678),
                   mkObs(1, 0, 0, 0, 0, 4'h0, 0, 32'hDEADBEEF, 0)};
      vecs[3]  = '{mkTxn(0, 2, 32'h40, 0, 1, 0, 32'h12345678),
                   mkObs(0, 0, 0, 0, 0, 4'h0, 0, 32'hDEADBEEF, 0)};
      vecs[4]  = '{mkTxn(1, 1, 32'h12, 32'h1234ABCD, 0, 2, 0),
                   mkObs(0, 4, 0, 1, 32'h10, 4'hC, 32'hABCD0000, 32'hDEADBEEF, 0)};
      vecs[5]  = '{mkTxn(0, 0, 32'h7, 0, 0, 1, 32'h11223344),
                   mkObs(0, 3, 1, 0, 32'h4, 4'h8, 0, 32'h11223344, 0)};
      vecs[6]  = '{mkTxn(0, 2, 32'h80, 0, 0, 4, 32'h55555555),
                   mkObs(0, 5, 1, 0, 32'h80, 4'hF, 0, 32'h11223344, 1)};
      vecs[7]  = '{mkTxn(0, 3, 32'h0, 0, 0, 0, 32'h66666666),
                   mkObs(0, 0, 0, 0, 0, 4'h0, 0, 32'h11223344, 0)};
      vecs[8]  = '{mkTxn(1, 2, 32'h2, 32'hFFFFFFFF, 0, 0, 0),
                   mkObs(1, 0, 0, 0, 0, 4'h0, 0, 32'h11223344, 0)};
      vecs[9]  = '{mkTxn(0, 1, 32'h2, 0, 0, 0, 32'hCAFEF00D),
                   mkObs(0, 2, 1, 0, 32'h0, 4'hC, 0, 32'hCAFEF00D, 0)};
      vecs[10] = '{mkTxn(1, 2, 32'h3FC, 32'h89ABCDEF, 0, 3, 0),
                   mkObs(0, 5, 0, 1, 32'h3FC, 4'hF, 32'h89ABCDEF, 32'hCAFEF00D, 0)};
      vecs[11] = '{mkTxn(0, 0, 32'h1, 0, 0, 0, 32'hFFEE00AB),
                   mkObs(0, 2, 1, 0, 32'h0, 4'h2, 0, 32'hFFEE00AB, 0)};

      bus.memoryBusy = 1'b0;
      bus.memoryDataRead = 32'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("reset.loadData", loadData, 32'd0);
      checkOutput("reset.busTimeout", 32'(busTimeout), 32'd0);
      checkOutput("reset.accessStall", 32'(accessStall), 32'd0);
      checkOutput("reset.enables", {30'd0, bus.memoryReadEnable, bus.memoryWriteEnable}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].in, got);
         compareObs($sformatf("vec%0d", i), got, vecs[i].exp);
      end
      modelLoad = vecs[11].exp.loadData;

      // A completed access must not restart while the pipe has not stepped.
      pipeStall = 1'b0;
      currentInstruction = mkInstr(0, 2, '0);
      aluResultData = 32'h30;
      bus.memoryBusy = 1'b0;
      bus.memoryDataRead = 32'h0BADF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("hold%0d.accessStall", k), 32'(accessStall), 32'd0);
         checkOutput($sformatf("hold%0d.readEn", k), 32'(bus.memoryReadEnable), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("hold.loadData", loadData, 32'h0BADF00D);
      stepPipe = 1'b1;
      currentInstruction = 32'h00000013;
      @(posedge clk); #1;
      stepPipe = 1'b0;

      // Reset during the second busy cycle of a word store.
      currentInstruction = mkInstr(1, 2, '0);
      aluResultData = 32'h20;
      rs2Data = 32'h13579BDF;
      bus.memoryBusy = 1'b1;
      @(posedge clk); #1;
      checkOutput("rstSeq.writeEnBefore", 32'(bus.memoryWriteEnable), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("rstSeq.writeEn", 32'(bus.memoryWriteEnable), 32'd0);
      checkOutput("rstSeq.accessStall", 32'(accessStall), 32'd0);
      checkOutput("rstSeq.loadData", loadData, 32'd0);
      checkOutput("rstSeq.address", bus.memoryAddress, 32'd0);
      currentInstruction = 32'h00000013;
      bus.memoryBusy = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rstSeq.idleStall", 32'(accessStall), 32'd0);
      modelLoad = 32'd0;

      // Wait counter must restart from zero: three busy cycles is below the limit.
      t = mkTxn(0, 2, 32'h44, 0, 0, 3, 32'h24681357);
      exp = model(t, modelLoad);
      applyStimulus(t, got);
      compareObs("postReset", got, exp);
      modelLoad = exp.loadData;

      for (int i = 0; i < 150; i++) begin
         t.kind  = 2'($urandom_range(0, 5) < 3 ? $urandom_range(0, 1) : $urandom_range(0, 2));
         t.size  = 2'($urandom_range(0, 3));
         t.addr  = $urandom;
         t.rs2   = $urandom;
         t.stall = ($urandom_range(0, 7) == 0);
         t.busy  = $urandom_range(0, 5);
         t.rdata = $urandom;
         t.noise = 23'($urandom);
         exp = model(t, modelLoad);
         applyStimulus(t, got);
         compareObs($sformatf("rand%0d", i), got, exp);
         modelLoad = exp.loadData;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
